ipfw_axil_regbank: RTL

//  Parametrised AXI4-Lite slave register bank for the IPFW datapath; successor of the fixed 4x32 slave.

---
 rtl/ipfw_regbank_pkg.sv | 24 ++
 rtl/ipfw_regbank_decode.sv | 27 ++
 rtl/ipfw_axil_regbank.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ipfw_regbank_pkg.sv
// Shared types and response codes for the IPFW AXI4-Lite register bank.
package ipfw_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    AXI_OKAY   = RESP_OKAY,
    AXI_SLVERR = RESP_SLVERR
  } axi_resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_GOT_A,
    WR_GOT_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/ipfw_regbank_decode.sv
// Word-index decode of an AXI byte address into control / status / out-of-range.
module ipfw_regbank_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CTRL   = 4,
  parameter int NUM_STAT   = 2,
  localparam int LSB       = $clog2(DATA_WIDTH/8),
  localparam int IDX_W     = ADDR_WIDTH - LSB
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  is_ctrl,
  output logic                  is_stat,
  output logic                  is_oor,
  output logic [IDX_W-1:0]      sel
);

  logic unused_lsb;

  assign unused_lsb = ^addr[LSB-1:0];
  assign sel        = addr[ADDR_WIDTH-1:LSB];

  // One extra bit so a register count equal to 2**IDX_W does not wrap to zero.
  assign is_ctrl = ({1'b0, sel} < (IDX_W+1)'(NUM_CTRL));
  assign is_stat = !is_ctrl && ({1'b0, sel} < (IDX_W+1)'(NUM_CTRL + NUM_STAT));
  assign is_oor  = !is_ctrl && !is_stat;

endmodule

// File: rtl/ipfw_axil_regbank.sv
// AXI4-Lite slave with NUM_CTRL R/W control and NUM_STAT RO status registers.
// Build option: define IPFW_REGBANK_SLVERR_EN to answer status writes and out-of-range accesses with SLVERR.
module ipfw_axil_regbank
  import ipfw_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CTRL   = 4,
  parameter int NUM_STAT   = 2,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RST = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_o,
  output logic [NUM_CTRL-1:0]            wr_pulse_o,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_i
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

  wr_state_t               wr_state, wr_nxt;
  rd_state_t               rd_state, rd_nxt;
  logic                    awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  axi_resp_t               bresp_q, rresp_q, wr_resp_d, rd_resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, cm_addr;
  logic [DATA_WIDTH-1:0]   wdata_q, cm_data;
  logic [STRB_W-1:0]       wstrb_q, cm_strb;
  logic [DATA_WIDTH-1:0]   ctrl_q [NUM_CTRL];
  logic [NUM_CTRL-1:0]     wr_pulse_q;
  logic                    aw_hs, w_hs, ar_hs, commit;
  logic                    w_ctrl, w_stat, w_oor, r_ctrl, r_stat, r_oor;
  logic [IDX_W-1:0]        w_sel, r_sel;
  logic                    unused_ok;

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  always_comb begin
    wr_nxt = wr_state;
    commit = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          wr_nxt = WR_RESP;
        end else if (aw_hs) begin
          wr_nxt = WR_GOT_A;
        end else if (w_hs) begin
          wr_nxt = WR_GOT_W;
        end
      end
      WR_GOT_A: if (w_hs) begin
        commit = 1'b1;
        wr_nxt = WR_RESP;
      end
      WR_GOT_W: if (aw_hs) begin
        commit = 1'b1;
        wr_nxt = WR_RESP;
      end
      WR_RESP: if (S_AXI_BREADY) wr_nxt = WR_IDLE;
      default: wr_nxt = WR_IDLE;
    endcase
  end

  // The half that arrived first comes from the holding registers, the other straight off the bus.
  assign cm_addr = (wr_state == WR_GOT_A) ? awaddr_q : S_AXI_AWADDR;
  assign cm_data = (wr_state == WR_GOT_W) ? wdata_q  : S_AXI_WDATA;
  assign cm_strb = (wr_state == WR_GOT_W) ? wstrb_q  : S_AXI_WSTRB;

  ipfw_regbank_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT)
  ) u_wr_dec (
    .addr(cm_addr), .is_ctrl(w_ctrl), .is_stat(w_stat), .is_oor(w_oor), .sel(w_sel)
  );

  ipfw_regbank_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT)
  ) u_rd_dec (
    .addr(S_AXI_ARADDR), .is_ctrl(r_ctrl), .is_stat(r_stat), .is_oor(r_oor), .sel(r_sel)
  );

`ifdef IPFW_REGBANK_SLVERR_EN
  assign wr_resp_d = w_ctrl ? AXI_OKAY : AXI_SLVERR;
  assign rd_resp_d = r_oor ? AXI_SLVERR : AXI_OKAY;
`else
  assign wr_resp_d = AXI_OKAY;
  assign rd_resp_d = AXI_OKAY;
`endif

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_stat, w_oor, r_oor};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state  <= WR_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wr_state  <= wr_nxt;
      awready_q <= (wr_nxt == WR_IDLE) || (wr_nxt == WR_GOT_W);
      wready_q  <= (wr_nxt == WR_IDLE) || (wr_nxt == WR_GOT_A);
      bvalid_q  <= (wr_nxt == WR_RESP);
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) bresp_q <= wr_resp_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RST[k*DATA_WIDTH +: DATA_WIDTH];
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit && w_ctrl) begin
        for (int k = 0; k < NUM_CTRL; k++) begin
          if (w_sel == IDX_W'(k)) begin
            wr_pulse_q[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (cm_strb[b]) ctrl_q[k][b*8 +: 8] <= cm_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux sees ctrl_q before any same-cycle commit lands.
  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      if (r_ctrl && r_sel == IDX_W'(k)) rdata_d = ctrl_q[k];
    for (int k = 0; k < NUM_STAT; k++)
      if (r_stat && r_sel == IDX_W'(NUM_CTRL + k)) rdata_d = stat_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    rd_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_nxt = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) rd_nxt = RD_IDLE;
      default: rd_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state  <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_OKAY;
    end else begin
      rd_state  <= rd_nxt;
      arready_q <= (rd_nxt == RD_IDLE);
      rvalid_q  <= (rd_nxt == RD_DATA);
      if (ar_hs) begin
        rdata_q <= rdata_d;
        rresp_q <= rd_resp_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_o
    assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

endmodule
